// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_pkg
//  Brief    : Shared constants and state encoding for the LFSR stream cipher
//  Revision : 1.0  initial release
// ============================================================================
package lfsr_pkg;

    // Default LFSR width and keystream word width
    localparam int unsigned LFSR_N_DEFAULT = 32;
    localparam int unsigned KEY_W_DEFAULT  = 8;

    // CRC-32 polynomial used as the default LFSR feedback taps
    localparam logic [31:0] TAPS_CRC32 = 32'h04C11DB7;

    // Cipher controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FILL = 2'd2,
        ST_HOLD = 2'd3
    } cipher_state_e;

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/keystream_packer.sv
`default_nettype none
// ============================================================================
//  Module   : keystream_packer
//  Brief    : Collects serial keystream bits MSB-first into a W-bit word and
//             flags the edge on which the last bit of a word is taken.
//  Revision : 1.0  initial release
// ============================================================================
module keystream_packer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         k_i,
    output logic [W-1:0] word_o,
    output logic         done_o
);

    localparam int unsigned         CNT_W  = $clog2(W + 1);
    localparam logic [CNT_W-1:0]    C_LAST = CNT_W'(W - 1);

    logic [W-1:0]     word_q;
    logic [W-1:0]     word_d;
    logic [CNT_W-1:0] bitcnt_q;
    logic [CNT_W-1:0] bitcnt_d;
    logic [W-1:0]     shifted;

    // The first bit taken ends up in the MSB once W bits have been shifted in
    generate
        if (W == 1) begin : g_shift_w1
            assign shifted = k_i;
        end else begin : g_shift_wn
            assign shifted = {word_q[W-2:0], k_i};
        end
    endgenerate

    // A clear in the same cycle wins, so a word is never reported complete while aborting
    assign done_o = en_i && !clr_i && (bitcnt_q == C_LAST);
    assign word_o = word_q;

    // Next-state: clear aborts a partial word, otherwise shift one bit per enabled cycle
    always_comb begin
        word_d   = word_q;
        bitcnt_d = bitcnt_q;
        if (clr_i) begin
            word_d   = '0;
            bitcnt_d = '0;
        end else if (en_i) begin
            word_d   = shifted;
            bitcnt_d = done_o ? '0 : bitcnt_q + 1'b1;
        end
    end

    // Shift register and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q   <= '0;
            bitcnt_q <= '0;
        end else begin
            word_q   <= word_d;
            bitcnt_q <= bitcnt_d;
        end
    end

endmodule : keystream_packer
`default_nettype wire

// File: rtl/lfsr_stream_cipher.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_stream_cipher
//  Brief    : Drives an external Galois LFSR, packs its serial output into
//             W-bit key words and XORs them with a valid/ready data stream.
//             One-entry output register; the next key word is prefetched
//             while the current ciphertext word waits to drain.
//  Revision : 1.0  initial release
// ============================================================================
module lfsr_stream_cipher
    import lfsr_pkg::*;
#(
    parameter int unsigned   N    = LFSR_N_DEFAULT,
    parameter int unsigned   W    = KEY_W_DEFAULT,
    parameter logic [N-1:0]  TAPS = N'(TAPS_CRC32)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         seed_ld,
    input  logic [N-1:0] seed,
    output logic         lfsr_ld,
    output logic         lfsr_en,
    output logic [N-1:0] lfsr_seed,
    output logic [N-1:0] lfsr_taps,
    input  logic         lfsr_k,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic [W-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         key_busy
);

    cipher_state_e state_q;
    cipher_state_e state_d;
    logic [N-1:0]  seed_q;
    logic [W-1:0]  dout_q;
    logic          dout_valid_q;
    logic          lfsr_ld_q;
    logic          lfsr_en_q;
    logic          key_busy_q;

    logic [W-1:0]  key_word;
    logic          key_done;
    logic          pack_en;
    logic          pack_clr;
    logic          din_hs;
    logic          dout_hs;

    assign lfsr_ld    = lfsr_ld_q;
    assign lfsr_en    = lfsr_en_q;
    assign lfsr_seed  = seed_q;
    assign lfsr_taps  = TAPS;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign key_busy   = key_busy_q;

    // A reseed request blocks acceptance so no word is ciphered with a stale key
    assign din_ready = (state_q == ST_HOLD) && !seed_ld && (!dout_valid_q || dout_ready);
    assign din_hs    = din_valid && din_ready;
    assign dout_hs   = dout_valid_q && dout_ready;

    // Packer shifts while filling; reseed or a fresh load starts the word from bit 0
    assign pack_en  = (state_q == ST_FILL);
    assign pack_clr = seed_ld || (state_q == ST_LOAD);

    keystream_packer #(
        .W (W)
    ) u_packer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (pack_en),
        .clr_i  (pack_clr),
        .k_i    (lfsr_k),
        .word_o (key_word),
        .done_o (key_done)
    );

    // Next-state selection; reseed has priority in every state
    always_comb begin
        state_d = state_q;
        if (seed_ld) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_LOAD: state_d = ST_FILL;
                ST_FILL: state_d = key_done ? ST_HOLD : ST_FILL;
                ST_HOLD: state_d = din_hs ? ST_FILL : ST_HOLD;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Controller state with registered Moore outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lfsr_ld_q  <= 1'b0;
            lfsr_en_q  <= 1'b0;
            key_busy_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            lfsr_ld_q  <= (state_d == ST_LOAD);
            lfsr_en_q  <= (state_d == ST_FILL);
            key_busy_q <= (state_d != ST_HOLD);
        end
    end

    // Seed capture for the LFSR load port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_q <= '0;
        end else if (seed_ld) begin
            seed_q <= seed;
        end
    end

    // Output register: reload on accept, otherwise clear once drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else if (din_hs) begin
            dout_q       <= din ^ key_word;
            dout_valid_q <= 1'b1;
        end else if (dout_hs) begin
            dout_valid_q <= 1'b0;
        end
    end

endmodule : lfsr_stream_cipher
`default_nettype wire

// File: tb/tb_lfsr_stream_cipher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lfsr_stream_cipher
//  Brief    : Bench for lfsr_stream_cipher with a behavioural Galois LFSR and
//             a word-level keystream model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lfsr_stream_cipher;

    localparam int unsigned  N    = 32;
    localparam int unsigned  W    = 8;
    localparam logic [N-1:0] TAPS = 32'h04C11DB7;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         seed_ld;
    logic [N-1:0] seed;
    logic         lfsr_ld;
    logic         lfsr_en;
    logic [N-1:0] lfsr_seed;
    logic [N-1:0] lfsr_taps;
    logic         lfsr_k;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         key_busy;

    int tests = 0;
    int fails = 0;

    lfsr_stream_cipher #(.N(N), .W(W), .TAPS(TAPS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_ld    (seed_ld),
        .seed       (seed),
        .lfsr_ld    (lfsr_ld),
        .lfsr_en    (lfsr_en),
        .lfsr_seed  (lfsr_seed),
        .lfsr_taps  (lfsr_taps),
        .lfsr_k     (lfsr_k),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .key_busy   (key_busy)
    );

    always #5 clk = ~clk;

    // One Galois step: shift left, fold taps in when the outgoing MSB is 1
    function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s);
        return {s[N-2:0], 1'b0} ^ (s[N-1] ? TAPS : '0);
    endfunction

    // Behavioural galois_lfsr paired with the DUT
    logic [N-1:0] lfsr_state = '0;
    always @(posedge clk) begin
        if (lfsr_ld)      lfsr_state <= lfsr_seed;
        else if (lfsr_en) lfsr_state <= lfsr_step(lfsr_state);
    end
    assign lfsr_k = lfsr_state[N-1];

    // Key word j after a seed: keystream bits j*W .. j*W+W-1, first bit in the MSB
    function automatic logic [W-1:0] key_word(input logic [N-1:0] sd, input int j);
        logic [N-1:0] s;
        logic [W-1:0] w;
        s = sd;
        w = '0;
        for (int i = 0; i < j * int'(W); i++) s = lfsr_step(s);
        for (int b = 0; b < int'(W); b++) begin
            w[W-1-b] = s[N-1];
            s = lfsr_step(s);
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model state and per-cycle compare ----------------
    logic [W-1:0] exp_q[$];
    logic [N-1:0] cur_seed  = '0;
    bit           have_seed = 1'b0;
    int           words     = 0;
    int           steps     = 0;
    int           ld_cnt    = 0;
    int           en_cnt    = 0;
    bit           prev_hold = 1'b0;
    bit           prev_ld   = 1'b0;
    logic [W-1:0] prev_dout = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            have_seed = 1'b0;
            words     = 0;
            steps     = 0;
            prev_hold = 1'b0;
            prev_ld   = 1'b0;
        end else begin
            chk("taps", lfsr_taps, TAPS);
            if (prev_hold) begin
                chk("held_valid", dout_valid, 1);
                chk("held_data", dout, prev_dout);
            end
            if (lfsr_ld) chk("ld_one_cycle", prev_ld, 0);
            if (seed_ld) chk("ready_on_seed", din_ready, 0);
            if (din_ready) begin
                chk("ready_key_steps", steps, W * (words + 1));
                chk("ready_outreg", (!dout_valid || dout_ready), 1);
            end
            chk("key_busy", key_busy,
                !(have_seed && !lfsr_ld && !lfsr_en && steps == int'(W) * (words + 1)));
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) chk("dout_unexpected", 1, 0);
                else                   chk("dout", dout, exp_q.pop_front());
            end
            if (din_valid && din_ready) begin
                exp_q.push_back(din ^ key_word(cur_seed, words));
                words++;
            end
            prev_hold = dout_valid && !dout_ready;
            prev_dout = dout;
            prev_ld   = lfsr_ld;
            if (lfsr_ld)      steps = 0;
            else if (lfsr_en) steps++;
            if (lfsr_ld) ld_cnt++;
            if (lfsr_en) en_cnt++;
            if (seed_ld) begin
                cur_seed  = seed;
                have_seed = 1'b1;
                words     = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_seed(input logic [N-1:0] s);
        seed_ld = 1'b1;
        seed    = s;
        cyc();
        seed_ld = 1'b0;
    endtask

    // Returns at the negedge where din_ready is first seen; n = cycles without it
    task automatic wait_ready(output int n);
        bit ok;
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (din_ready) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (!ok) chk("wait_ready_timeout", 0, 1);
    endtask

    // Offers one word until accepted; returns at +1 after the accepting edge
    task automatic send_word(input logic [W-1:0] d);
        bit ok;
        bit hs;
        ok = 1'b0;
        cyc();
        din       = d;
        din_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            hs = din_ready;
            cyc();
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        din_valid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_en(input int cnt);
        int c;
        c = 0;
        for (int i = 0; i < 100 && c < cnt; i++) begin
            @(negedge clk);
            if (lfsr_en) c++;
        end
        if (c != cnt) chk("wait_en_timeout", c, cnt);
        cyc();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ld"},        lfsr_ld, 0);
        chk({tag, "_en"},        lfsr_en, 0);
        chk({tag, "_seed"},      lfsr_seed, 0);
        chk({tag, "_taps"},      lfsr_taps, TAPS);
        chk({tag, "_din_ready"}, din_ready, 0);
        chk({tag, "_dout"},      dout, 0);
        chk({tag, "_dout_vld"},  dout_valid, 0);
        chk({tag, "_key_busy"},  key_busy, 1);
    endtask

    // ---------------- directed and random sequences ----------------
    initial begin
        int           n;
        int           ld0;
        int           en0;
        logic [W-1:0] d;

        rst_n      = 1'b0;
        seed_ld    = 1'b0;
        seed       = '0;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;

        repeat (3) cyc();
        @(negedge clk);
        check_reset_outputs("rst");
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle");
        cyc();

        // 1: first key word for seed 0x80000000 is 0x82
        do_seed(32'h8000_0000);
        ld0 = ld_cnt;
        en0 = en_cnt;
        wait_ready(n);
        chk("t1_latency", n, W + 1);
        chk("t1_ld_pulses", ld_cnt - ld0, 1);
        chk("t1_en_pulses", en_cnt - en0, W);
        send_word(8'h00);
        @(negedge clk);
        chk("t1_dout", dout, 8'h82);

        // 2: same seed, din 0xFF, then the following word from the model
        cyc();
        do_seed(32'h8000_0000);
        wait_ready(n);
        send_word(8'hFF);
        @(negedge clk);
        chk("t2_dout", dout, 8'h7D);
        wait_ready(n);
        d = W'($urandom);
        send_word(d);
        @(negedge clk);
        chk("t2_next", dout, d ^ key_word(32'h8000_0000, 1));

        // 3: backpressure, then simultaneous drain and accept
        cyc();
        dout_ready = 1'b0;
        wait_ready(n);
        send_word(W'($urandom));
        din       = W'($urandom);
        din_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("t3_bp_ready", din_ready, 0);
            cyc();
        end
        dout_ready = 1'b1;
        @(negedge clk);
        chk("t3_b2b_ready", din_ready, 1);
        cyc();
        din_valid = 1'b0;
        @(negedge clk);
        chk("t3_b2b_valid", dout_valid, 1);
        cyc();

        // 4: reseed in the middle of a fill
        do_seed(32'h1234_5678);
        wait_en(3);
        do_seed(32'hCAFE_F00D);
        ld0 = ld_cnt;
        en0 = en_cnt;
        wait_ready(n);
        chk("t4_latency", n, W + 1);
        chk("t4_ld_pulses", ld_cnt - ld0, 1);
        chk("t4_en_pulses", en_cnt - en0, W);
        d = W'($urandom);
        send_word(d);
        @(negedge clk);
        chk("t4_dout", dout, d ^ key_word(32'hCAFE_F00D, 0));
        cyc();

        // 5: reseed coinciding with an offered word while a dout is pending
        dout_ready = 1'b0;
        wait_ready(n);
        send_word(W'($urandom));
        repeat (12) cyc();
        dout_ready = 1'b1;
        din        = W'($urandom);
        din_valid  = 1'b1;
        seed_ld    = 1'b1;
        seed       = 32'h0BAD_BEEF;
        @(negedge clk);
        chk("t5_ready_blocked", din_ready, 0);
        chk("t5_pending_valid", dout_valid, 1);
        cyc();
        seed_ld   = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        chk("t5_drained", dout_valid, 0);
        wait_ready(n);
        send_word(W'($urandom));

        // 6: asynchronous reset in the middle of a fill
        do_seed(32'h5A5A_A5A5);
        wait_en(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        cyc();
        rst_n = 1'b1;
        ld0 = ld_cnt;
        en0 = en_cnt;
        repeat (20) cyc();
        chk("t6_no_en", en_cnt - en0, 0);
        chk("t6_no_ld", ld_cnt - ld0, 0);
        chk("t6_busy", key_busy, 1);

        // Random traffic with occasional reseeds
        do_seed($urandom);
        for (int i = 0; i < 600; i++) begin
            din_valid  = ($urandom_range(0, 9) < 7);
            din        = W'($urandom);
            dout_ready = ($urandom_range(0, 9) < 6);
            seed_ld    = ($urandom_range(0, 63) == 0);
            seed       = $urandom;
            cyc();
        end
        din_valid  = 1'b0;
        seed_ld    = 1'b0;
        dout_ready = 1'b1;
        repeat (5) cyc();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule : tb_lfsr_stream_cipher
`default_nettype wire
